// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - shared widths, depths, IDCT coefficients and lane vector type
package idct_pkg;

    localparam int DW    = 16;
    localparam int OW    = 24;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int NVEC  = 4;

    localparam int C64  = 64;
    localparam int C36  = 36;
    localparam int CN64 = -64;
    localparam int CN83 = -83;

    typedef struct packed {
        logic [DW-1:0] c4;
        logic [DW-1:0] c3;
        logic [DW-1:0] c2;
        logic [DW-1:0] c1;
    } idct_vec_t;

    // Index width that stays at least one bit for single-entry structures.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/idct_out_fifo.sv
// rtl/idct_out_fifo.sv - register-based first-word-fall-through result FIFO
module idct_out_fifo
    import idct_pkg::*;
#(
    parameter int WIDTH   = OW + 1,
    parameter int ENTRIES = DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = clog2_min1(ENTRIES);
    localparam int CW = $clog2(ENTRIES + 1);

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop     = pop_i && !empty_o;
    assign full_o     = (count_q == CW'(ENTRIES));
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];

    // Storage, pointers and fill count; a push into a full FIFO is only legal alongside a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i))
        else $fatal(1, "idct_out_fifo overflow");

endmodule

// File: rtl/idct_issue_ctrl.sv
// rtl/idct_issue_ctrl.sv - credit-based issue scheduler with lane skew for the 4-tap IDCT datapath
module idct_issue_ctrl
    import idct_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data_1,
    input  logic [DW-1:0] s_data_2,
    input  logic [DW-1:0] s_data_3,
    input  logic [DW-1:0] s_data_4,
    output logic [DW-1:0] d_in_1,
    output logic [DW-1:0] d_in_2,
    output logic [DW-1:0] d_in_3,
    output logic [DW-1:0] d_in_4,
    input  logic [OW-1:0] dp_out,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [OW-1:0] m_data,
    output logic          m_last,
    output logic          busy
);

    localparam int OCW = $clog2(DEPTH + 1);
    localparam int VW  = clog2_min1(NVEC);

    logic           started_q;
    logic [OCW-1:0] occ_q;
    logic [OCW-1:0] occ_d;
    logic [VW-1:0]  vec_idx_q;
    logic [LAT:0]   vpipe_q;
    logic [LAT:0]   lpipe_q;
    logic [DW-1:0]  lane1_q;
    logic [DW-1:0]  lane2_q [2];
    logic [DW-1:0]  lane3_q [3];
    logic [DW-1:0]  lane4_q [4];
    logic           issue;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [OW:0]    fifo_rdata;

    // Credits count both buffered and in-flight results, so a granted issue always has a FIFO slot.
    assign s_ready = started_q && (occ_q < OCW'(DEPTH));
    assign issue   = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign busy    = (occ_q != '0);

    assign d_in_1 = lane1_q;
    assign d_in_2 = lane2_q[1];
    assign d_in_3 = lane3_q[2];
    assign d_in_4 = lane4_q[3];

    // Occupancy next state: issue adds a credit in use, pop returns one.
    always_comb begin
        occ_d = occ_q;
        case ({issue, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Control state: ready gate after reset release, credits and block position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_q <= 1'b0;
            occ_q     <= '0;
            vec_idx_q <= '0;
        end else begin
            started_q <= 1'b1;
            occ_q     <= occ_d;
            if (issue) begin
                vec_idx_q <= (vec_idx_q == VW'(NVEC - 1)) ? '0 : vec_idx_q + 1'b1;
            end
        end
    end

    // Skew lanes: lane k reaches the datapath k cycles after issue; idle cycles inject zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane1_q <= '0;
            for (int i = 0; i < 2; i++) lane2_q[i] <= '0;
            for (int i = 0; i < 3; i++) lane3_q[i] <= '0;
            for (int i = 0; i < 4; i++) lane4_q[i] <= '0;
        end else begin
            lane1_q    <= issue ? s_data_1 : '0;
            lane2_q[0] <= issue ? s_data_2 : '0;
            lane2_q[1] <= lane2_q[0];
            lane3_q[0] <= issue ? s_data_3 : '0;
            lane3_q[1] <= lane3_q[0];
            lane3_q[2] <= lane3_q[1];
            lane4_q[0] <= issue ? s_data_4 : '0;
            lane4_q[1] <= lane4_q[0];
            lane4_q[2] <= lane4_q[1];
            lane4_q[3] <= lane4_q[2];
        end
    end

    // Valid and last-tag pipes track each vector until its sum appears on dp_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpipe_q <= '0;
            lpipe_q <= '0;
        end else begin
            vpipe_q <= {vpipe_q[LAT-1:0], issue};
            lpipe_q <= {lpipe_q[LAT-1:0], issue && (vec_idx_q == VW'(NVEC - 1))};
        end
    end

    idct_out_fifo #(
        .WIDTH   (OW + 1),
        .ENTRIES (DEPTH)
    ) u_out_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (vpipe_q[LAT]),
        .push_data_i ({lpipe_q[LAT], dp_out}),
        .pop_i       (pop),
        .pop_data_o  (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_rdata[OW-1:0];
    assign m_last  = fifo_rdata[OW];

endmodule

// File: tb/tb_idct_issue_ctrl.sv
// tb/tb_idct_issue_ctrl.sv - directed self-checking bench with a behavioural transposed IDCT datapath
module tb_idct_issue_ctrl;
    import idct_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data_1 = '0;
    logic [DW-1:0] s_data_2 = '0;
    logic [DW-1:0] s_data_3 = '0;
    logic [DW-1:0] s_data_4 = '0;
    logic [DW-1:0] d_in_1, d_in_2, d_in_3, d_in_4;
    logic [OW-1:0] dp_out;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [OW-1:0] m_data;
    logic          m_last;
    logic          busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idct_issue_ctrl dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data_1(s_data_1), .s_data_2(s_data_2), .s_data_3(s_data_3), .s_data_4(s_data_4),
        .d_in_1(d_in_1), .d_in_2(d_in_2), .d_in_3(d_in_3), .d_in_4(d_in_4),
        .dp_out(dp_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy)
    );

    // Free-running transposed datapath: three adder-chain registers, combinational final sum.
    logic signed [OW-1:0] x1, x2, x3, x4;
    logic signed [OW-1:0] r1 = '0, r2 = '0, r3 = '0;
    assign x1 = OW'($signed(d_in_1));
    assign x2 = OW'($signed(d_in_2));
    assign x3 = OW'($signed(d_in_3));
    assign x4 = OW'($signed(d_in_4));
    always @(posedge clk) begin
        r1 <= OW'(C64 * x1);
        r2 <= OW'(r1 + C36 * x2);
        r3 <= OW'(r2 + CN64 * x3);
    end
    assign dp_out = OW'(r3 + CN83 * x4);

    function automatic idct_vec_t mk(input int a, input int b, input int c, input int d);
        idct_vec_t v;
        v.c1 = a[DW-1:0];
        v.c2 = b[DW-1:0];
        v.c3 = c[DW-1:0];
        v.c4 = d[DW-1:0];
        return v;
    endfunction

    function automatic logic [OW-1:0] to_ow(input int x);
        return x[OW-1:0];
    endfunction

    task automatic drive(input idct_vec_t v, input logic vld);
        s_data_1 = v.c1;
        s_data_2 = v.c2;
        s_data_3 = v.c3;
        s_data_4 = v.c4;
        s_valid  = vld;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(mk(0, 0, 0, 0), 1'b0);
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 ||
            d_in_1 !== '0 || d_in_2 !== '0 || d_in_3 !== '0 || d_in_4 !== '0) begin
            failures++;
            $display("FAIL reset_state: s_ready=%b m_valid=%b busy=%b d_in=%h/%h/%h/%h required all 0",
                     s_ready, m_valid, busy, d_in_1, d_in_2, d_in_3, d_in_4);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge: s_ready=%b required 0", s_ready);
        end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_edge: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_single(input idct_vec_t v, input int lane_chk, input int exp);
        logic [DW-1:0] lane_val;
        m_ready = 1'b0;
        drive(v, 1'b1);
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready: s_ready=%b required 1", s_ready);
        end
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) drive(mk(0, 0, 0, 0), 1'b0);
            if (cyc == lane_chk) begin
                lane_val = (lane_chk == 1) ? d_in_1 : d_in_4;
                checks++;
                if (lane_val !== ((lane_chk == 1) ? v.c1 : v.c4)) begin
                    failures++;
                    $display("FAIL single_lane%0d_skew: got %h required %h", lane_chk, lane_val,
                             (lane_chk == 1) ? v.c1 : v.c4);
                end
            end
            if (cyc == 4) begin
                checks++;
                if (m_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL single_early_valid: m_valid=%b required 0 at N+4", m_valid);
                end
            end
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== to_ow(exp) || m_last !== 1'b0) begin
            failures++;
            $display("FAIL single_result: valid=%b data=%h last=%b required 1/%h/0",
                     m_valid, m_data, m_last, to_ow(exp));
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: m_valid=%b busy=%b required 0/0", m_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        idct_vec_t tab [4];
        int exp [4];
        tab[0] = mk(1, 1, 1, 1);  exp[0] = -47;
        tab[1] = mk(2, 0, 0, 0);  exp[1] = 128;
        tab[2] = mk(0, 2, 0, 0);  exp[2] = 72;
        tab[3] = mk(0, 0, 0, -1); exp[3] = 83;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(tab[i], 1'b1);
            @(negedge clk);
        end
        drive(mk(0, 0, 0, 0), 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== to_ow(exp[k]) || m_last !== (k == 3)) begin
                failures++;
                $display("FAIL b2b_result%0d: valid=%b data=%h last=%b required 1/%h/%b",
                         k, m_valid, m_data, m_last, to_ow(exp[k]), (k == 3));
            end
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_tail: m_valid=%b required 0", m_valid);
        end
    endtask

    task automatic test_backpressure();
        idct_vec_t tab [5];
        int exp [4];
        int n = 0;
        int got = 0;
        tab[0] = mk(1, 0, 0, 0); exp[0] = 64;
        tab[1] = mk(0, 1, 0, 0); exp[1] = 36;
        tab[2] = mk(0, 0, 1, 0); exp[2] = -64;
        tab[3] = mk(0, 0, 0, 1); exp[3] = -83;
        tab[4] = mk(2, 0, 0, 0);
        m_ready = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            drive(tab[n], 1'b1);
            if (s_ready) n++;
            @(negedge clk);
        end
        checks++;
        if (n !== DEPTH || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_credit_stop: issues=%0d s_ready=%b required %0d/0", n, s_ready, DEPTH);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== to_ow(64)) begin
            failures++;
            $display("FAIL bp_hold: valid=%b data=%h required 1/%h", m_valid, m_data, to_ow(64));
        end
        drive(mk(0, 0, 0, 0), 1'b0);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (m_valid) begin
                checks++;
                if (got >= 4 || m_data !== to_ow(exp[got]) || m_last !== (got == 3)) begin
                    failures++;
                    $display("FAIL bp_result%0d: data=%h last=%b required %h/%b", got, m_data,
                             m_last, (got < 4) ? to_ow(exp[got]) : '0, (got == 3));
                end
                got++;
            end
            @(negedge clk);
        end
        m_ready = 1'b0;
        checks++;
        if (got !== 4 || s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: results=%0d s_ready=%b busy=%b required 4/1/0", got, s_ready, busy);
        end
    endtask

    task automatic test_bubbles();
        int got = 0;
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive(mk(1, 1, 1, 1), (c < 8) && (c % 2 == 0));
            #1;
            if (m_valid) begin
                checks++;
                if (m_data !== to_ow(-47)) begin
                    failures++;
                    $display("FAIL bubble_result%0d: data=%h required %h", got, m_data, to_ow(-47));
                end
                got++;
            end
            @(negedge clk);
        end
        drive(mk(0, 0, 0, 0), 1'b0);
        m_ready = 1'b0;
        checks++;
        if (got !== 4) begin
            failures++;
            $display("FAIL bubble_count: results=%0d required 4", got);
        end
    endtask

    task automatic test_reset_midstream();
        int spurious = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(mk(1, 0, 0, 0), 1'b1);
            @(negedge clk);
        end
        drive(mk(0, 0, 0, 0), 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_prefill: m_valid=%b busy=%b required 1/1", m_valid, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || d_in_1 !== '0) begin
            failures++;
            $display("FAIL mid_async_clear: m_valid=%b busy=%b s_ready=%b d_in_1=%h required 0/0/0/0",
                     m_valid, busy, s_ready, d_in_1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_valid !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            failures++;
            $display("FAIL mid_discard: spurious_cycles=%0d required 0", spurious);
        end
        test_single(mk(0, 2, 0, 0), 1, 72);
    endtask

    initial begin
        test_reset();
        test_single(mk(1, 0, 0, 0), 1, 64);
        test_single(mk(0, 0, 0, 1), 4, -83);
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
